// File: rtl/alu_seq_control.sv
// ALU operation decoder with a registered, handshaked result and an optional multi-cycle (MDU) sequencer.
// Define MDU_MULTICYCLE_EN to enable the MUL/MULH/DIV/REM sequencer; otherwise those selectors decode as illegal.
module alu_seq_control #(
  parameter int OP_W    = 4,
  parameter int MDU_LAT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      ALU_Op_i,
  input  logic [2:0]      funct3_i,
  output logic [OP_W-1:0] ALU_Operation_o,
  output logic            op_valid_o,
  output logic            illegal_o,
  output logic            mdu_start_o,
  output logic            stall_o
);

  if (OP_W < 4) begin : g_bad_op_w
    $error("alu_seq_control: OP_W must be at least 4");
  end
  if (MDU_LAT < 2 || MDU_LAT > 255) begin : g_bad_lat
    $error("alu_seq_control: MDU_LAT must be in 2..255");
  end

  typedef struct packed {
    logic       legal;
    logic       multi;
    logic [3:0] code;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] f7, input logic [2:0] aop, input logic [2:0] f3);
    dec_t d;
    d.legal = 1'b1;
    d.multi = 1'b0;
    d.code  = 4'b0000;
    case (aop)
      3'b000: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  d.code = 4'b0000;
            3'b001:  d.code = 4'b0011;
            3'b100:  d.code = 4'b1000;
            3'b101:  d.code = 4'b0100;
            3'b110:  d.code = 4'b0010;
            3'b111:  d.code = 4'b0111;
            default: d.legal = 1'b0;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d.code = 4'b0101;
        end else if (f7 == 7'b0000001) begin
          d.multi = 1'b1;
          case (f3)
            3'b000:  d.code = 4'b1101;
            3'b001:  d.code = 4'b1110;
            3'b100:  d.code = 4'b1111;
            3'b110:  d.code = 4'b0110;
            default: d.legal = 1'b0;
          endcase
        end else begin
          d.legal = 1'b0;
        end
      end
      3'b001: begin
        case (f3)
          3'b000:  d.code = 4'b0000;
          3'b100:  d.code = 4'b1000;
          3'b110:  d.code = 4'b0010;
          3'b111:  d.code = 4'b0111;
          3'b001:  if (f7 == 7'b0000000) d.code = 4'b0011; else d.legal = 1'b0;
          3'b101:  if (f7 == 7'b0000000) d.code = 4'b0100; else d.legal = 1'b0;
          default: d.legal = 1'b0;
        endcase
      end
      3'b010: d.code = 4'b0001;
      3'b011: begin
        case (f3)
          3'b000:  d.code = 4'b1001;
          3'b001:  d.code = 4'b1010;
          3'b100:  d.code = 4'b1011;
          3'b101:  d.code = 4'b1100;
          default: d.legal = 1'b0;
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    if (!d.legal) begin
      d.multi = 1'b0;
      d.code  = 4'b0000;
    end
    return d;
  endfunction

  // Stage p0: combinational decode of the incoming selector
  dec_t dec_p0;
  assign dec_p0 = decode(funct7_i, ALU_Op_i, funct3_i);

  // Stage p1: registered operation code and handshake pulses
  logic [OP_W-1:0] op_p1;
  logic            vld_p1;
  logic            illegal_p1;

`ifdef MDU_MULTICYCLE_EN
  localparam int CNT_W = $clog2(MDU_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             start_p1;
  logic             stall_p1;

  // The counter runs MDU_LAT-1 .. 0; the result pulse is raised on the 1->0 step
  // and the FSM leaves BUSY one edge later, so the exit edge never samples valid_i.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op_p1      <= '0;
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      start_p1   <= 1'b0;
      stall_p1   <= 1'b0;
    end else begin
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      start_p1   <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            op_p1 <= OP_W'(dec_p0.code);
            if (dec_p0.multi) begin
              state    <= BUSY;
              cnt      <= CNT_W'(MDU_LAT - 1);
              start_p1 <= 1'b1;
              stall_p1 <= 1'b1;
            end else begin
              vld_p1     <= 1'b1;
              illegal_p1 <= !dec_p0.legal;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              stall_p1 <= 1'b0;
              vld_p1   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mdu_start_o = start_p1;
  assign stall_o     = stall_p1;
`else
  // Without the sequencer every accept completes in one cycle; MDU selectors report illegal.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_p1      <= '0;
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      if (valid_i) begin
        op_p1      <= dec_p0.multi ? '0 : OP_W'(dec_p0.code);
        vld_p1     <= 1'b1;
        illegal_p1 <= !dec_p0.legal || dec_p0.multi;
      end
    end
  end

  assign mdu_start_o = 1'b0;
  assign stall_o     = 1'b0;
`endif

  assign ALU_Operation_o = op_p1;
  assign op_valid_o      = vld_p1;
  assign illegal_o       = illegal_p1;

endmodule

// File: tb/tb_alu_seq_control.sv
// Testbench for alu_seq_control: directed scenarios plus randomized traffic against a rule-table reference model.
module tb_alu_seq_control;
  localparam int OP_W = 5;
  localparam int L    = 8;
  localparam logic [12:0] FULL = 13'h1FFF;
  localparam logic [12:0] NOF7 = 13'h003F;
  localparam logic [12:0] AOP  = 13'h0038;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_i;
  logic [6:0]      funct7_i;
  logic [2:0]      ALU_Op_i;
  logic [2:0]      funct3_i;
  logic [OP_W-1:0] ALU_Operation_o;
  logic            op_valid_o;
  logic            illegal_o;
  logic            mdu_start_o;
  logic            stall_o;

  always #5 clk = ~clk;

  alu_seq_control #(.OP_W(OP_W), .MDU_LAT(L)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .funct7_i(funct7_i), .ALU_Op_i(ALU_Op_i),
    .funct3_i(funct3_i), .ALU_Operation_o(ALU_Operation_o), .op_valid_o(op_valid_o),
    .illegal_o(illegal_o), .mdu_start_o(mdu_start_o), .stall_o(stall_o)
  );

  typedef struct {
    logic [12:0] val;
    logic [12:0] mask;
    logic [3:0]  code;
    bit          multi;
  } rule_t;
  rule_t rules[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: busy flag, cycle index since a multi-cycle accept, and held code
  bit         m_busy = 0;
  int         m_t    = 0;
  logic [3:0] m_code = '0;
  bit e_opv, e_ill, e_start, e_stall;

  function void add_rule(logic [12:0] val, logic [12:0] mask, logic [3:0] code, bit multi);
    rule_t r;
    r.val = val; r.mask = mask; r.code = code; r.multi = multi;
    rules.push_back(r);
  endfunction

  function automatic void ref_decode(input logic [12:0] sel, output bit hit,
                                     output logic [3:0] code, output bit multi);
    hit = 0; code = '0; multi = 0;
    foreach (rules[i])
      if (!hit && ((sel & rules[i].mask) == (rules[i].val & rules[i].mask))) begin
        hit = 1; code = rules[i].code; multi = rules[i].multi;
      end
  endfunction

  task automatic drive(input bit v, input logic [12:0] sel);
    valid_i = v;
    {funct7_i, ALU_Op_i, funct3_i} = sel;
  endtask

  task automatic check(input string tag);
    logic [OP_W-1:0] e_op;
    e_op = {1'b0, m_code};
    n_checks++;
    assert (ALU_Operation_o === e_op) else begin
      n_fail++; $error("FAIL %s ALU_Operation_o got %b expected %b", tag, ALU_Operation_o, e_op);
    end
    n_checks++;
    assert (op_valid_o === e_opv) else begin
      n_fail++; $error("FAIL %s op_valid_o got %b expected %b", tag, op_valid_o, e_opv);
    end
    n_checks++;
    assert (illegal_o === e_ill) else begin
      n_fail++; $error("FAIL %s illegal_o got %b expected %b", tag, illegal_o, e_ill);
    end
    n_checks++;
    assert (mdu_start_o === e_start) else begin
      n_fail++; $error("FAIL %s mdu_start_o got %b expected %b", tag, mdu_start_o, e_start);
    end
    n_checks++;
    assert (stall_o === e_stall) else begin
      n_fail++; $error("FAIL %s stall_o got %b expected %b", tag, stall_o, e_stall);
    end
  endtask

  // One clock edge: model the request seen at the edge, then compare the cycle after it
  task automatic edge_step(input string tag);
    bit r, v, hit, mul;
    logic [12:0] sel;
    logic [3:0]  code;
    r = reset; v = valid_i; sel = {funct7_i, ALU_Op_i, funct3_i};
    @(posedge clk);
    #1;
    e_opv = 0; e_ill = 0; e_start = 0; e_stall = 0;
    if (r) begin
      m_busy = 0; m_code = '0;
    end else if (m_busy) begin
      m_t++;
      if (m_t > L) m_busy = 0;
    end else if (v) begin
      ref_decode(sel, hit, code, mul);
`ifndef MDU_MULTICYCLE_EN
      if (mul) hit = 0;
`endif
      if (!hit) begin
        m_code = '0; e_opv = 1; e_ill = 1;
      end else if (mul) begin
        m_code = code; m_busy = 1; m_t = 1;
      end else begin
        m_code = code; e_opv = 1;
      end
    end
    if (m_busy) begin
      e_start = (m_t == 1);
      e_stall = (m_t <= L - 1);
      e_opv   = (m_t == L);
    end
    check(tag);
  endtask

  initial begin
    logic [12:0] sel, rnd;
    add_rule({7'b0000000, 3'b000, 3'b000}, FULL, 4'b0000, 0);
    add_rule({7'b0000000, 3'b000, 3'b001}, FULL, 4'b0011, 0);
    add_rule({7'b0000000, 3'b000, 3'b100}, FULL, 4'b1000, 0);
    add_rule({7'b0000000, 3'b000, 3'b101}, FULL, 4'b0100, 0);
    add_rule({7'b0000000, 3'b000, 3'b110}, FULL, 4'b0010, 0);
    add_rule({7'b0000000, 3'b000, 3'b111}, FULL, 4'b0111, 0);
    add_rule({7'b0100000, 3'b000, 3'b000}, FULL, 4'b0101, 0);
    add_rule({7'b0000000, 3'b001, 3'b000}, NOF7, 4'b0000, 0);
    add_rule({7'b0000000, 3'b001, 3'b100}, NOF7, 4'b1000, 0);
    add_rule({7'b0000000, 3'b001, 3'b110}, NOF7, 4'b0010, 0);
    add_rule({7'b0000000, 3'b001, 3'b111}, NOF7, 4'b0111, 0);
    add_rule({7'b0000000, 3'b001, 3'b001}, FULL, 4'b0011, 0);
    add_rule({7'b0000000, 3'b001, 3'b101}, FULL, 4'b0100, 0);
    add_rule({7'b0000000, 3'b010, 3'b000}, AOP,  4'b0001, 0);
    add_rule({7'b0000000, 3'b011, 3'b000}, NOF7, 4'b1001, 0);
    add_rule({7'b0000000, 3'b011, 3'b001}, NOF7, 4'b1010, 0);
    add_rule({7'b0000000, 3'b011, 3'b100}, NOF7, 4'b1011, 0);
    add_rule({7'b0000000, 3'b011, 3'b101}, NOF7, 4'b1100, 0);
    add_rule({7'b0000001, 3'b000, 3'b000}, FULL, 4'b1101, 1);
    add_rule({7'b0000001, 3'b000, 3'b001}, FULL, 4'b1110, 1);
    add_rule({7'b0000001, 3'b000, 3'b100}, FULL, 4'b1111, 1);
    add_rule({7'b0000001, 3'b000, 3'b110}, FULL, 4'b0110, 1);

    // Reset held two cycles with a request present; reset must win
    reset = 1'b1;
    drive(1'b1, {7'b0000000, 3'b000, 3'b000});
    repeat (2) edge_step("reset");
    reset = 1'b0;
    drive(1'b0, '0);
    repeat (3) edge_step("idle_after_reset");

    // Back-to-back sweep of every single-cycle selector, random don't-care bits
    foreach (rules[i]) begin
      if (!rules[i].multi) begin
        rnd = 13'($urandom);
        drive(1'b1, (rules[i].val & rules[i].mask) | (rnd & ~rules[i].mask));
        edge_step("sweep");
      end
    end
    drive(1'b1, {7'b0100000, 3'b000, 3'b000});
    edge_step("sub");
    drive(1'b0, '0);
    edge_step("sweep_end");

    // MUL with inputs released, run past the exit edge
    drive(1'b1, {7'b0000001, 3'b000, 3'b000});
    edge_step("mul_accept");
    drive(1'b0, '0);
    repeat (L + 2) edge_step("mul_busy");

    // DIV with an ADD request held high throughout
    drive(1'b1, {7'b0000001, 3'b000, 3'b100});
    edge_step("div_accept");
    drive(1'b1, {7'b0000000, 3'b000, 3'b000});
    repeat (L + 3) edge_step("div_hold_add");
    drive(1'b0, '0);
    edge_step("div_hold_end");

    // DIV aborted by reset in its third busy cycle, then an ADD
    drive(1'b1, {7'b0000001, 3'b000, 3'b100});
    edge_step("div2_accept");
    drive(1'b0, '0);
    repeat (2) edge_step("div2_busy");
    reset = 1'b1;
    edge_step("div2_reset");
    reset = 1'b0;
    drive(1'b1, {7'b0000000, 3'b000, 3'b000});
    edge_step("add_after_abort");
    drive(1'b0, '0);
    repeat (L + 1) edge_step("after_abort");

    // Illegal selectors
    drive(1'b1, {7'b1111111, 3'b000, 3'b011});
    edge_step("illegal");
    drive(1'b1, {7'b0100000, 3'b000, 3'b101});
    edge_step("illegal_sra");
    drive(1'b1, {7'b0000000, 3'b111, 3'b000});
    edge_step("illegal_aop");
    drive(1'b0, '0);
    edge_step("illegal_end");

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      rnd = 13'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        int k;
        k = $urandom_range(0, rules.size() - 1);
        sel = (rules[k].val & rules[k].mask) | (rnd & ~rules[k].mask);
      end else begin
        sel = rnd;
      end
      drive($urandom_range(0, 2) != 0, sel);
      edge_step("random");
    end
    reset = 1'b0;
    drive(1'b0, '0);
    repeat (L + 2) edge_step("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_control.md
ALU_SEQ_CONTROL -- requirements
Module: alu_seq_control

Interface
REQ-001 SHALL have parameter OP_W, default 4: width of ALU_Operation_o; must be >= 4; codes are zero-extended.
REQ-002 SHALL have parameter MDU_LAT, default 8: cycles from accept to result for multi-cycle ops; legal range 2..255.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port valid_i, input, 1: the decode request is present this cycle.
REQ-006 SHALL have port funct7_i, input, 7: instruction funct7 field.
REQ-007 SHALL have port ALU_Op_i, input, 3: op class from the main control unit.
REQ-008 SHALL have port funct3_i, input, 3: instruction funct3 field.
REQ-009 SHALL have port ALU_Operation_o, output, OP_W: registered ALU operation code.
REQ-010 SHALL have port op_valid_o, output, 1: one-cycle pulse; ALU_Operation_o is final.
REQ-011 SHALL have port illegal_o, output, 1: one-cycle pulse; the accepted selector is unmatched.
REQ-012 SHALL have port mdu_start_o, output, 1: one-cycle pulse that launches a multi-cycle op.
REQ-013 SHALL have port stall_o, output, 1: the block is busy and upstream must hold.

Function
REQ-014 SHALL decode selector {funct7_i, ALU_Op_i, funct3_i}, with x = don't care, as follows:
- R-type, ALU_Op 000, funct7 0000000: ADD f3=000 -> 0000; SLL 001 -> 0011; XOR 100 -> 1000; SRL 101 -> 0100; OR 110 -> 0010; AND 111 -> 0111.
- R-type SUB, funct7 0100000, f3=000 -> 0101.
- I-type, ALU_Op 001, funct7 x: ADDI 000 -> 0000; XORI 100 -> 1000; ORI 110 -> 0010; ANDI 111 -> 0111.
- I-type shifts, ALU_Op 001, funct7 0000000: SLLI 001 -> 0011; SRLI 101 -> 0100.
- LUI, ALU_Op 010, funct7 x, f3 x -> 0001.
- Branches, ALU_Op 011, funct7 x: BEQ 000 -> 1001; BNE 001 -> 1010; BLT 100 -> 1011; BGE 101 -> 1100.
REQ-015 SHALL decode multi-cycle ops, ALU_Op 000, funct7 0000001: MUL f3=000 -> 1101; MULH 001 -> 1110; DIV 100 -> 1111; REM 110 -> 0110.
REQ-016 SHALL implement FSM states IDLE and BUSY; valid_i is sampled only in IDLE.
REQ-017 Single-cycle or illegal op accepted at edge N SHALL:
- load ALU_Operation_o at edge N;
- assert op_valid_o for exactly cycle N+1;
- stay in IDLE.
REQ-018 Illegal selector SHALL:
- load ALU_Operation_o = 0;
- pulse illegal_o together with op_valid_o;
- assert no stall_o.
REQ-019 Multi-cycle op accepted at edge N SHALL:
- load ALU_Operation_o at edge N and enter BUSY;
- pulse mdu_start_o in cycle N+1;
- hold stall_o high in cycles N+1..N+MDU_LAT-1;
- pulse op_valid_o in cycle N+MDU_LAT with stall_o low;
- be back in IDLE at edge N+MDU_LAT.
REQ-020 SHALL use a down-counter of width ceil(log2(MDU_LAT+1)), loaded with MDU_LAT-1 on accept; BUSY exits when the counter reaches 0; no wrap-around.
REQ-021 valid_i or input changes during BUSY SHALL be ignored; ALU_Operation_o SHALL be held until the next accept.
REQ-022 valid_i at edge N+MDU_LAT, the BUSY exit edge, SHALL NOT be accepted; a new request SHALL be accepted no earlier than edge N+MDU_LAT+1.
REQ-023 Back-to-back single-cycle requests SHALL be accepted every cycle, giving one op_valid_o pulse each.

Reset
REQ-024 reset high at a rising edge SHALL force state IDLE, counter 0, ALU_Operation_o 0, and op_valid_o, illegal_o, mdu_start_o, stall_o 0.
REQ-025 reset SHALL override valid_i in the same cycle.
REQ-026 reset during BUSY SHALL abort the op with no op_valid_o pulse; the first accept is possible at the first edge with reset low.

Configuration
REQ-027 Macro MDU_MULTICYCLE_EN:
- defined: REQ-015, REQ-019 and REQ-020 are active;
- undefined: MUL, MULH, DIV and REM selectors are illegal per REQ-018, and no counter or BUSY state is synthesised;
- undefined: mdu_start_o and stall_o are tied to 0.

Verification
REQ-028 Reset held 2 cycles then released -> every output is 0 and no pulse appears while valid_i = 0.
REQ-029 Sweep every REQ-014 selector, each with valid_i for 1 cycle -> the listed code appears next cycle with op_valid_o = 1; e.g. {0100000,000,000} -> 0101.
REQ-030 MUL, i.e. {0000001,000,000}, accepted at edge 0 with MDU_LAT = 8 -> mdu_start_o in cycle 1, stall_o in cycles 1..7, op_valid_o in cycle 8, code 1101.
REQ-031 valid_i held high with an ADD during DIV BUSY -> ADD is ignored until DIV op_valid_o; ADD is accepted at the next edge after exit.
REQ-032 reset at cycle 3 of DIV BUSY -> no op_valid_o, outputs 0, and a following ADD completes normally.
REQ-033 {1111111,000,011} -> ALU_Operation_o = 0000 with illegal_o = op_valid_o = 1 for one cycle; with MDU_MULTICYCLE_EN undefined, MUL gives the same response.
